// File: rtl/axis_move_scheduler_if.sv
// Signal bundle between the tracker front end and the motor-drive sequencer.
//   slave  : the scheduler side. It receives the mode select, the LDR pairs and the angle pairs,
//            and it drives the four 2-bit motor buses, active_axis and sweep_done.
//   master : the driving side, such as a testbench or the tracker top level.
interface axis_move_scheduler_if #(
  parameter int unsigned W = 16
);
  logic         sma;
  logic [W-1:0] R_vertical_1;
  logic [W-1:0] R_vertical_2;
  logic [W-1:0] R_horizontal_1;
  logic [W-1:0] R_horizontal_2;
  logic [W-1:0] theta_manual;
  logic [W-1:0] theta_actual;
  logic [W-1:0] phi_manual;
  logic [W-1:0] phi_actual;
  logic [1:0]   s_out_theta_pos;
  logic [1:0]   s_out_theta_neg;
  logic [1:0]   s_out_phi_pos;
  logic [1:0]   s_out_phi_neg;
  logic         active_axis;
  logic         sweep_done;

  modport slave (
    input  sma, R_vertical_1, R_vertical_2, R_horizontal_1, R_horizontal_2,
    input  theta_manual, theta_actual, phi_manual, phi_actual,
    output s_out_theta_pos, s_out_theta_neg, s_out_phi_pos, s_out_phi_neg,
    output active_axis, sweep_done
  );

  modport master (
    output sma, R_vertical_1, R_vertical_2, R_horizontal_1, R_horizontal_2,
    output theta_manual, theta_actual, phi_manual, phi_actual,
    input  s_out_theta_pos, s_out_theta_neg, s_out_phi_pos, s_out_phi_neg,
    input  active_axis, sweep_done
  );
endinterface

// File: rtl/axis_move_scheduler.sv
// Motor-drive sequencer for the solar tracker.
// The block samples the per-axis errors. In automatic mode these come from the LDR pair
// differences, and in manual mode from the setpoint minus the actual angle. It then time-slices
// one shared motor driver: theta first, then phi. Each move burst lasts MOVE_CYCLES cycles and
// is followed by an all-off gap of DEAD_CYCLES cycles. At most one bus is nonzero at any time.
// Ports:
//   clk    : system clock
//   rst    : asynchronous reset, active low
//   bus_io : slave side of axis_move_scheduler_if. It carries the inputs and the motor codes
//            (00 = off, 01 = slow, 10 = fast), active_axis (0 = theta, 1 = phi) and
//            sweep_done (one-cycle pulse at the end of each sweep).
module axis_move_scheduler #(
  parameter int unsigned W           = 16,
  parameter int unsigned DEADBAND    = 2,
  parameter int unsigned FAST_THRESH = 20,
  parameter int unsigned MOVE_CYCLES = 1000,
  parameter int unsigned DEAD_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_move_scheduler_if.slave  bus_io
);

  localparam int unsigned MaxCycles = (MOVE_CYCLES > DEAD_CYCLES) ? MOVE_CYCLES : DEAD_CYCLES;
  localparam int unsigned TimerW    = $clog2(MaxCycles + 1);

  localparam logic [TimerW-1:0] MoveLoad    = TimerW'(MOVE_CYCLES - 1);
  localparam logic [TimerW-1:0] DeadLoad    = TimerW'(DEAD_CYCLES - 1);
  localparam logic [W:0]        DeadbandMag = (W + 1)'(DEADBAND);
  localparam logic [W:0]        FastMag     = (W + 1)'(FAST_THRESH);

  typedef enum logic [2:0] {StIdle, StSample, StCheck, StMove, StGap} state_e;

  state_e state_q, state_d;

  logic              axis_q, axis_d;
  logic              abort_q, abort_d;
  logic              mode_q, mode_d;
  logic [TimerW-1:0] timer_q, timer_d;
  // Errors are held as W+1-bit two's complement; bit W is the sign.
  logic [W:0]        theta_err_q, theta_err_d;
  logic [W:0]        phi_err_q, phi_err_d;

  logic [1:0] theta_pos_q, theta_pos_d;
  logic [1:0] theta_neg_q, theta_neg_d;
  logic [1:0] phi_pos_q, phi_pos_d;
  logic [1:0] phi_neg_q, phi_neg_d;
  logic       sweep_done_q, sweep_done_d;

  logic [W:0] theta_err_in, phi_err_in;
  logic [W:0] sel_err, sel_mag;
  logic       sel_move, sel_neg;
  logic [1:0] move_code;

  // Live error sources. The inputs are zero-extended first, so the W+1-bit difference is exact.
  always_comb begin
    if (bus_io.sma) begin
      theta_err_in = {1'b0, bus_io.R_vertical_1} - {1'b0, bus_io.R_vertical_2};
      phi_err_in   = {1'b0, bus_io.R_horizontal_1} - {1'b0, bus_io.R_horizontal_2};
    end else begin
      theta_err_in = {1'b0, bus_io.theta_manual} - {1'b0, bus_io.theta_actual};
      phi_err_in   = {1'b0, bus_io.phi_manual} - {1'b0, bus_io.phi_actual};
    end
  end

  // Decode the latched error of the currently selected axis.
  always_comb begin
    sel_err   = axis_q ? phi_err_q : theta_err_q;
    sel_neg   = sel_err[W];
    sel_mag   = sel_neg ? (~sel_err + 1'b1) : sel_err;
    sel_move  = (sel_mag > DeadbandMag);
    move_code = (sel_mag >= FastMag) ? 2'b10 : 2'b01;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    axis_d      = axis_q;
    abort_d     = abort_q;
    mode_d      = mode_q;
    timer_d     = timer_q;
    theta_err_d = theta_err_q;
    phi_err_d   = phi_err_q;
    unique case (state_q)
      StIdle: begin
        state_d = StSample;
      end
      StSample: begin
        theta_err_d = theta_err_in;
        phi_err_d   = phi_err_in;
        mode_d      = bus_io.sma;
        axis_d      = 1'b0;
        abort_d     = 1'b0;
        state_d     = StCheck;
      end
      StCheck: begin
        if (sel_move) begin
          state_d = StMove;
          timer_d = MoveLoad;
        end else if (!axis_q) begin
          axis_d = 1'b1;
        end else begin
          state_d = StSample;
        end
      end
      StMove: begin
        // A mode change ends the burst at once. The sweep is then finished after the gap.
        if (bus_io.sma != mode_q) begin
          abort_d = 1'b1;
          state_d = StGap;
          timer_d = DeadLoad;
        end else if (timer_q == '0) begin
          state_d = StGap;
          timer_d = DeadLoad;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StGap: begin
        if (timer_q == '0) begin
          if (!axis_q && !abort_q) begin
            axis_d  = 1'b1;
            state_d = StCheck;
          end else begin
            state_d = StSample;
          end
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered outputs are decoded from the next state, so a bus is nonzero exactly while the
  // FSM sits in StMove. The axis does not change between StCheck and StMove, which makes
  // axis_q a valid selector here.
  always_comb begin
    theta_pos_d  = 2'b00;
    theta_neg_d  = 2'b00;
    phi_pos_d    = 2'b00;
    phi_neg_d    = 2'b00;
    if (state_d == StMove) begin
      if (!axis_q) begin
        if (sel_neg) begin
          theta_neg_d = move_code;
        end else begin
          theta_pos_d = move_code;
        end
      end else begin
        if (sel_neg) begin
          phi_neg_d = move_code;
        end else begin
          phi_pos_d = move_code;
        end
      end
    end
    sweep_done_d = (state_d == StSample) && ((state_q == StCheck) || (state_q == StGap));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      axis_q       <= 1'b0;
      abort_q      <= 1'b0;
      mode_q       <= 1'b0;
      timer_q      <= '0;
      theta_err_q  <= '0;
      phi_err_q    <= '0;
      theta_pos_q  <= 2'b00;
      theta_neg_q  <= 2'b00;
      phi_pos_q    <= 2'b00;
      phi_neg_q    <= 2'b00;
      sweep_done_q <= 1'b0;
    end else begin
      axis_q       <= axis_d;
      abort_q      <= abort_d;
      mode_q       <= mode_d;
      timer_q      <= timer_d;
      theta_err_q  <= theta_err_d;
      phi_err_q    <= phi_err_d;
      theta_pos_q  <= theta_pos_d;
      theta_neg_q  <= theta_neg_d;
      phi_pos_q    <= phi_pos_d;
      phi_neg_q    <= phi_neg_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign bus_io.s_out_theta_pos = theta_pos_q;
  assign bus_io.s_out_theta_neg = theta_neg_q;
  assign bus_io.s_out_phi_pos   = phi_pos_q;
  assign bus_io.s_out_phi_neg   = phi_neg_q;
  assign bus_io.active_axis     = axis_q;
  assign bus_io.sweep_done      = sweep_done_q;

endmodule

// File: tb/tb_axis_move_scheduler.sv
// Self-checking bench for axis_move_scheduler with MOVE_CYCLES=8 and DEAD_CYCLES=4.
// With static inputs, the expected output trace is built sweep by sweep from the sequencing
// rules and compared cycle by cycle. A long random run checks the bus invariants.
module tb_axis_move_scheduler;
  localparam int W  = 16;
  localparam int DB = 2;
  localparam int FT = 20;
  localparam int M  = 8;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Trace entry: {theta_pos, theta_neg, phi_pos, phi_neg, active_axis, sweep_done}
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  axis_move_scheduler_if #(.W(W)) bus ();

  axis_move_scheduler #(
    .W          (W),
    .DEADBAND   (DB),
    .FAST_THRESH(FT),
    .MOVE_CYCLES(M),
    .DEAD_CYCLES(D)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  function automatic logic [9:0] obs();
    return {bus.s_out_theta_pos, bus.s_out_theta_neg, bus.s_out_phi_pos, bus.s_out_phi_neg,
            bus.active_axis, bus.sweep_done};
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [1:0] code_of(input int mag);
    return (mag >= FT) ? 2'b10 : 2'b01;
  endfunction

  // One sweep is SAMPLE, a theta check with an optional burst and gap, and a phi check with an
  // optional burst and gap. The sweep is closed by the next SAMPLE, which the caller appends.
  function automatic void push_sweep(input int te, input int pe, input logic prev_axis,
                                     input logic sd);
    logic [1:0] tc;
    logic [1:0] pc;
    tc = code_of(iabs(te));
    pc = code_of(iabs(pe));
    exp_q.push_back({8'h00, prev_axis, sd});
    exp_q.push_back({8'h00, 1'b0, 1'b0});
    if (iabs(te) > DB) begin
      for (int i = 0; i < M; i++)
        exp_q.push_back({(te > 0) ? tc : 2'b00, (te < 0) ? tc : 2'b00, 4'h0, 2'b00});
      for (int i = 0; i < D; i++) exp_q.push_back(10'h000);
    end
    exp_q.push_back({8'h00, 1'b1, 1'b0});
    if (iabs(pe) > DB) begin
      for (int i = 0; i < M; i++)
        exp_q.push_back({4'h0, (pe > 0) ? pc : 2'b00, (pe < 0) ? pc : 2'b00, 1'b1, 1'b0});
      for (int i = 0; i < D; i++) exp_q.push_back({8'h00, 1'b1, 1'b0});
    end
  endfunction

  function automatic void build_static(input int te, input int pe);
    exp_q.delete();
    exp_q.push_back(10'h000);
    push_sweep(te, pe, 1'b0, 1'b0);
    push_sweep(te, pe, 1'b1, 1'b1);
    push_sweep(te, pe, 1'b1, 1'b1);
  endfunction

  // Applies the inputs, pulses reset, and releases it on a falling edge. The unused input
  // group gets random values, so that a wrong mode selection becomes visible.
  task automatic drive_static(input logic s, input int a, input int b, input int c, input int d);
    @(negedge clk);
    rst = 1'b0;
    bus.sma = s;
    if (s) begin
      bus.R_vertical_1   = W'(a);
      bus.R_vertical_2   = W'(b);
      bus.R_horizontal_1 = W'(c);
      bus.R_horizontal_2 = W'(d);
      bus.theta_manual   = W'($urandom_range(0, 60000));
      bus.theta_actual   = W'($urandom_range(0, 60000));
      bus.phi_manual     = W'($urandom_range(0, 60000));
      bus.phi_actual     = W'($urandom_range(0, 60000));
    end else begin
      bus.theta_manual   = W'(a);
      bus.theta_actual   = W'(b);
      bus.phi_manual     = W'(c);
      bus.phi_actual     = W'(d);
      bus.R_vertical_1   = W'($urandom_range(0, 60000));
      bus.R_vertical_2   = W'($urandom_range(0, 60000));
      bus.R_horizontal_1 = W'($urandom_range(0, 60000));
      bus.R_horizontal_2 = W'($urandom_range(0, 60000));
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.sma = 1'b0;
    bus.R_vertical_1 = '0;   bus.R_vertical_2 = '0;
    bus.R_horizontal_1 = '0; bus.R_horizontal_2 = '0;
    bus.theta_manual = '0;   bus.theta_actual = '0;
    bus.phi_manual = '0;     bus.phi_actual = '0;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.s_out_theta_pos !== 2'b00) begin
      errors++; $display("FAIL reset_theta_pos: got %b, expected 00", bus.s_out_theta_pos);
    end
    checks++;
    if (bus.s_out_theta_neg !== 2'b00) begin
      errors++; $display("FAIL reset_theta_neg: got %b, expected 00", bus.s_out_theta_neg);
    end
    checks++;
    if (bus.s_out_phi_pos !== 2'b00) begin
      errors++; $display("FAIL reset_phi_pos: got %b, expected 00", bus.s_out_phi_pos);
    end
    checks++;
    if (bus.s_out_phi_neg !== 2'b00) begin
      errors++; $display("FAIL reset_phi_neg: got %b, expected 00", bus.s_out_phi_neg);
    end
    checks++;
    if (bus.active_axis !== 1'b0) begin
      errors++; $display("FAIL reset_active_axis: got %b, expected 0", bus.active_axis);
    end
    checks++;
    if (bus.sweep_done !== 1'b0) begin
      errors++; $display("FAIL reset_sweep_done: got %b, expected 0", bus.sweep_done);
    end
  endtask

  task automatic test_reset_mid_burst();
    drive_static(1'b1, 30, 5, 5, 5);
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (bus.s_out_theta_pos !== 2'b10) begin
      errors++; $display("FAIL midrst_burst_on: got %b, expected 10", bus.s_out_theta_pos);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs() !== 10'h000) begin
      errors++; $display("FAIL midrst_async_clear: got %b, expected %b", obs(), 10'h000);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 10'h000) begin
      errors++; $display("FAIL midrst_idle: got %b, expected %b", obs(), 10'h000);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs() !== 10'h000) begin
      errors++; $display("FAIL midrst_check: got %b, expected %b", obs(), 10'h000);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.s_out_theta_pos !== 2'b10) begin
      errors++; $display("FAIL midrst_first_burst: got %b, expected 10", bus.s_out_theta_pos);
    end
  endtask

  task automatic test_auto();
    logic [9:0] exp_v;
    int idx;
    build_static(30 - 5, 5 - 5);
    drive_static(1'b1, 30, 5, 5, 5);
    idx = 0;
    while (exp_q.size() > 0) begin
      if (idx > 0) @(negedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL auto_trace cycle %0d: got %b, expected %b", idx, obs(), exp_v);
      end
      idx++;
    end
  endtask

  task automatic test_manual();
    logic [9:0] exp_v;
    int idx;
    build_static(5 - 45, 30 - 27);
    drive_static(1'b0, 5, 45, 30, 27);
    idx = 0;
    while (exp_q.size() > 0) begin
      if (idx > 0) @(negedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL manual_trace cycle %0d: got %b, expected %b", idx, obs(), exp_v);
      end
      idx++;
    end
  endtask

  task automatic test_deadband();
    int dt[6] = '{2, 20, 19, -20, 3, -2};
    int dp[6] = '{2, 2, -3, -19, -2, 20};
    logic [9:0] exp_v;
    int idx;
    for (int k = 0; k < 6; k++) begin
      build_static(dt[k], dp[k]);
      drive_static(1'b1, 100 + dt[k], 100, 100 + dp[k], 100);
      idx = 0;
      while (exp_q.size() > 0) begin
        if (idx > 0) @(negedge clk);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs() !== exp_v) begin
          errors++;
          $display("FAIL deadband case %0d (te=%0d pe=%0d) cycle %0d: got %b, expected %b",
                   k, dt[k], dp[k], idx, obs(), exp_v);
        end
        idx++;
      end
    end
  endtask

  // Theta starts a fast burst in automatic mode. The mode flips 3 burst cycles in, so the burst
  // is cut, phi is skipped, and the next sweep runs on the manual errors (theta 0, phi -30).
  task automatic test_abort();
    logic [9:0] exp_v;
    int idx;
    exp_q.delete();
    exp_q.push_back(10'h000);
    exp_q.push_back(10'h000);
    exp_q.push_back(10'h000);
    for (int i = 0; i < 3; i++) exp_q.push_back({2'b10, 8'h00});
    for (int i = 0; i < D; i++) exp_q.push_back(10'h000);
    push_sweep(0, 10 - 40, 1'b0, 1'b1);
    exp_q.push_back({8'h00, 1'b1, 1'b1});
    drive_static(1'b1, 30, 5, 5, 5);
    bus.theta_manual = W'(50);
    bus.theta_actual = W'(50);
    bus.phi_manual   = W'(10);
    bus.phi_actual   = W'(40);
    idx = 0;
    while (exp_q.size() > 0) begin
      if (idx > 0) @(negedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL abort_trace cycle %0d: got %b, expected %b", idx, obs(), exp_v);
      end
      if (idx == 5) bus.sma = 1'b0;
      idx++;
    end
  endtask

  task automatic test_random_static();
    logic [9:0] exp_v;
    int idx;
    int a, b, c, d;
    logic s;
    for (int k = 0; k < 10; k++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 60);
      b = $urandom_range(0, 60);
      c = $urandom_range(0, 60);
      d = $urandom_range(0, 60);
      build_static(a - b, c - d);
      drive_static(s, a, b, c, d);
      idx = 0;
      while (exp_q.size() > 0) begin
        if (idx > 0) @(negedge clk);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs() !== exp_v) begin
          errors++;
          $display("FAIL rnd_static run %0d (te=%0d pe=%0d) cycle %0d: got %b, expected %b",
                   k, a - b, c - d, idx, obs(), exp_v);
        end
        idx++;
      end
    end
  endtask

  task automatic test_random_invariants();
    logic [1:0] c[4];
    logic [1:0] cur_code;
    int nz, b, cur_bus, burst_len, gap_len;
    bit in_burst, seen_burst, toggled, any11;
    in_burst = 0; seen_burst = 0; toggled = 0;
    cur_bus = 0; cur_code = 2'b00; burst_len = 0; gap_len = 0;
    drive_static(1'($urandom_range(0, 1)), $urandom_range(0, 60), $urandom_range(0, 60),
                 $urandom_range(0, 60), $urandom_range(0, 60));
    for (int n = 0; n < 10000; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      c[0] = bus.s_out_theta_pos;
      c[1] = bus.s_out_theta_neg;
      c[2] = bus.s_out_phi_pos;
      c[3] = bus.s_out_phi_neg;
      nz = 0; b = 0; any11 = 0;
      for (int k = 0; k < 4; k++) begin
        if (c[k] != 2'b00) begin
          nz++;
          b = k;
        end
        if (c[k] == 2'b11) any11 = 1;
      end
      checks++;
      if (nz > 1) begin
        errors++; $display("FAIL rnd_onehot cycle %0d: %0d buses nonzero, expected <= 1", n, nz);
      end
      checks++;
      if (any11) begin
        errors++; $display("FAIL rnd_code11 cycle %0d: got code 11 on a bus, expected none", n);
      end
      if (nz == 1) begin
        checks++;
        if (bus.active_axis !== logic'(b >= 2)) begin
          errors++;
          $display("FAIL rnd_axis cycle %0d: active_axis %b, expected %b for bus %0d",
                   n, bus.active_axis, logic'(b >= 2), b);
        end
        if (!in_burst) begin
          if (seen_burst) begin
            checks++;
            if (gap_len < D) begin
              errors++;
              $display("FAIL rnd_gap cycle %0d: gap of %0d cycles, expected >= %0d", n, gap_len, D);
            end
          end
          in_burst = 1; cur_bus = b; cur_code = c[b]; burst_len = 1;
        end else begin
          checks++;
          if (b != cur_bus || c[b] !== cur_code) begin
            errors++;
            $display("FAIL rnd_burst_hold cycle %0d: bus %0d code %b, expected bus %0d code %b",
                     n, b, c[b], cur_bus, cur_code);
          end
          burst_len++;
        end
      end else if (nz == 0) begin
        if (in_burst) begin
          checks++;
          if (!(burst_len == M || (burst_len < M && toggled))) begin
            errors++;
            $display("FAIL rnd_burst_len cycle %0d: burst of %0d cycles, expected %0d",
                     n, burst_len, M);
          end
          in_burst = 0; seen_burst = 1; gap_len = 1;
        end else begin
          gap_len++;
        end
      end
      if (bus.sweep_done) toggled = 0;
      if ($urandom_range(0, 39) == 0) begin
        bus.sma = ~bus.sma;
        toggled = 1;
      end
      bus.R_vertical_1   = W'($urandom_range(0, 60));
      bus.R_vertical_2   = W'($urandom_range(0, 60));
      bus.R_horizontal_1 = W'($urandom_range(0, 60));
      bus.R_horizontal_2 = W'($urandom_range(0, 60));
      bus.theta_manual   = W'($urandom_range(0, 60));
      bus.theta_actual   = W'($urandom_range(0, 60));
      bus.phi_manual     = W'($urandom_range(0, 60));
      bus.phi_actual     = W'($urandom_range(0, 60));
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_auto();
    test_manual();
    test_deadband();
    test_abort();
    test_random_static();
    test_random_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_move_scheduler.md
Name: axis_move_scheduler

Overview:
- Sequencer for the solar-tracker motor drive.
- Samples the LDR pair readings (automatic mode) or the manual/actual angle pairs (manual mode) and computes a signed error per axis.
- Time-slices the shared motor driver: theta first, then phi, with a dead-time gap after every move.
- Drives the same four 2-bit motor buses consumed downstream. At most one axis and one direction is active at any time.

Parameters:
- W, 16, width of sensor and angle inputs.
- DEADBAND, 2, error magnitude at or below which an axis is not moved.
- FAST_THRESH, 20, error magnitude at or above which the fast code is used.
- MOVE_CYCLES, 1000, clock cycles a move burst lasts (≥1).
- DEAD_CYCLES, 100, clock cycles of all-off gap after a move or abort (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- sma  in  1  mode select: 1 = automatic (LDR), 0 = manual.
- R_vertical_1, R_vertical_2  in  W  vertical LDR pair.
- R_horizontal_1, R_horizontal_2  in  W  horizontal LDR pair.
- theta_manual, theta_actual  in  W  theta setpoint and position.
- phi_manual, phi_actual  in  W  phi setpoint and position.
- s_out_theta_pos, s_out_theta_neg  out  2  theta motor codes.
- s_out_phi_pos, s_out_phi_neg  out  2  phi motor codes.
- active_axis  out  1  0 = theta slot, 1 = phi slot.
- sweep_done  out  1  one-cycle pulse when a theta+phi sweep completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE, axis=0, timer=0, abort=0.
  - All motor outputs 2'b00; active_axis=0; sweep_done=0.
- Error arithmetic, computed at W+1 bits signed:
  - Automatic: theta_err = R_vertical_1 − R_vertical_2; phi_err = R_horizontal_1 − R_horizontal_2.
  - Manual: theta_err = theta_manual − theta_actual; phi_err = phi_manual − phi_actual.
  - mag = |err| at W+1 bits unsigned; no overflow is possible.
- Motor code: 2'b00 = off, 2'b01 = slow, 2'b10 = fast. 2'b11 is never emitted.
  - fast when mag ≥ FAST_THRESH, else slow.
  - err > 0 drives the _pos bus; err < 0 drives the _neg bus.
- All outputs are registered and change only on clk edges.
- States:
  - IDLE: 1 cycle after reset release → SAMPLE.
  - SAMPLE: latch theta_err, phi_err and sma (mode_q); axis←0; abort←0 → CHECK.
  - CHECK: if mag[axis] > DEADBAND → MOVE, timer←MOVE_CYCLES−1. Otherwise, if axis=0 → axis←1, stay in CHECK; if axis=1 → SAMPLE with sweep_done=1.
  - MOVE: the selected axis bus carries its code and every other bus is 00. The code is held for exactly MOVE_CYCLES cycles from latched values; input changes are ignored. At timer=0 → GAP, timer←DEAD_CYCLES−1. If sma≠mode_q → abort←1, → GAP immediately; outputs read 00 from the next edge.
  - GAP: all buses 00 for exactly DEAD_CYCLES cycles. At timer=0: if axis=0 and abort=0 → axis←1, CHECK. Otherwise → SAMPLE with sweep_done=1.
- Invariants:
  - Never two nonzero buses in the same cycle.
  - Every 00 interval between two nonzero bursts lasts ≥ DEAD_CYCLES cycles, including a direction reversal across sweeps.
- Boundaries:
  - mag = DEADBAND → no move.
  - mag = FAST_THRESH → fast.
  - Both axes inside the deadband → SAMPLE→CHECK→CHECK→SAMPLE loop, sweep_done every 3 cycles.
  - Reset asserted mid-MOVE clears outputs asynchronously, without waiting for a clock.
- active_axis mirrors the axis register.
- sweep_done is high only in the cycle the FSM enters SAMPLE from CHECK or GAP.

Test Plan (all scenarios use MOVE_CYCLES=8, DEAD_CYCLES=4):
1. Reset with rst=0 mid-burst → all buses 00 immediately. Release rst → first SAMPLE 1 cycle later.
2. sma=1, R_vertical_1=30, R_vertical_2=5, R_horizontal_1=R_horizontal_2=5 →
   - s_out_theta_pos=2'b10 for exactly 8 cycles, then 4 cycles of 00.
   - phi skipped; sweep_done pulses; sweep repeats.
3. sma=0, theta_manual=5, theta_actual=45 (err −40), phi_manual=30, phi_actual=27 (err +3) →
   - theta_neg=2'b10 for 8 cycles, then a 4-cycle gap.
   - phi_pos=2'b01 for 8 cycles, then a 4-cycle gap, then sweep_done.
4. Deadband edges:
   - phi err = +2 → phi never driven.
   - err = +20 → 2'b10.
   - err = +19 → 2'b01.
5. Toggle sma 3 cycles into a theta burst →
   - bus 00 on the next edge, 4-cycle gap, phi slot skipped, sweep_done, SAMPLE with the new mode.
6. Random inputs for 10k cycles → checker confirms:
   - never two nonzero buses at once; never code 11;
   - every burst is 8 cycles unless aborted;
   - every gap between bursts is ≥ 4 cycles.
